dac_playout: RTL and testbench
==============================

Name: dac_playout

Overview:
- Downstream consumer of the 14-bit sample FIFO. Drains the FIFO at a fixed DAC sample rate and drives a parallel DAC: data, sample clock and valid strobe.
- Primes the FIFO before starting playback, then detects and recovers from underrun.
- Sits between the FIFO read port and the DAC pins.

Parameters:
- DATA_WIDTH, 14, sample width; matches FIFO width.
- CNT_WIDTH, 6, width of the FIFO occupancy input (clog2 of FIFO depth 64).
- SAMPLE_RATE, 4, clk cycles per DAC sample. Must be even and >= 4.
- PRIME_LEVEL, 32, occupancy required before playback starts or resumes. Must be < FIFO depth − 1.
- TWOS_TO_OFFSET, 1, when 1, FIFO data is two's complement and the DAC takes offset binary (MSB inverted).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  playback enable, level
- fifo_rd_en  out  1  FIFO read strobe; one clk per sample
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; registered by the FIFO, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_count  in  CNT_WIDTH  FIFO occupancy
- dac_data  out  DATA_WIDTH  DAC code, registered
- dac_clk  out  1  DAC sample clock, registered
- dac_valid  out  1  one-cycle pulse when dac_data updates
- underrun  out  1  one-cycle pulse per underrun event
- underrun_cnt  out  16  underrun event count, saturating
- state  out  2  current FSM state, for debug

Behaviour:
- Reset (async, active-low) values:
  - state = IDLE, div_cnt = 0.
  - fifo_rd_en, dac_clk, dac_valid, underrun = 0; underrun_cnt = 0.
  - dac_data = conv(0), i.e. 0x2000 with TWOS_TO_OFFSET = 1, else 0.
  - Reset mid-operation aborts any in-flight capture.
- conv(x) = TWOS_TO_OFFSET ? {~x[MSB], x[MSB-1:0]} : x.
- States: IDLE = 0, PRIME = 1, PLAY = 2, UNDERRUN = 3.
  - Any state with enable = 0 → IDLE next cycle. This has priority over all other transitions.
  - IDLE: enable = 1 → PRIME.
  - PRIME: fifo_count >= PRIME_LEVEL → PLAY, with div_cnt = 0 on PLAY entry.
  - PLAY: tick with fifo_empty = 1 → UNDERRUN.
  - UNDERRUN: fifo_count >= PRIME_LEVEL → PLAY, with div_cnt = 0 on entry.
- div_cnt:
  - Counts 0..SAMPLE_RATE−1 and wraps, only in PLAY and UNDERRUN.
  - Forced to 0 in IDLE and PRIME.
  - tick = (state == PLAY && div_cnt == 0).
- Read/capture pipeline:
  - On tick with fifo_empty = 0: fifo_rd_en = 1 for exactly that cycle (cycle N).
  - cycle N+1: fifo_rd_data is sampled.
  - cycle N+2: dac_data = conv(sample) and dac_valid = 1 for one cycle.
  - Latency from fifo_rd_en to dac_data is 2 clk.
  - A capture already issued completes even if enable drops or state changes.
- Underrun handling:
  - Tick with fifo_empty = 1: no fifo_rd_en, dac_data holds its value, underrun pulses for 1 cycle.
  - underrun_cnt increments and saturates at 0xFFFF. It is cleared only by reset.
- dac_clk:
  - In PLAY/UNDERRUN: registered output of (div_cnt < SAMPLE_RATE/2).
  - Otherwise 0.
  - dac_data therefore changes half a sample period after the dac_clk rising edge, while dac_clk is low, giving the DAC setup/hold.
- In IDLE, PRIME and UNDERRUN: fifo_rd_en is never asserted and dac_data holds its last value.
- Read rule: fifo_rd_en is never asserted while fifo_empty = 1. This is the FIFO's protection against count wrap.
- fifo_count is compared unsigned at full CNT_WIDTH.

Decomposition:
- Shared package adda_pkg holds:
  - the state enum (2 bits);
  - DATA_WIDTH default (14);
  - the conv() function.
- One sub-module, dac_tick_gen, holds div_cnt, tick and dac_clk generation; its inputs are a run level and a sync-clear.
- The FSM, capture pipeline and underrun counter stay in dac_playout.

Test Plan:
- Reset then enable = 1 with fifo_count = 10 → state stays PRIME, no fifo_rd_en. Raise fifo_count to 32 → PLAY next cycle, first fifo_rd_en on the following cycle.
- PLAY, SAMPLE_RATE = 4, FIFO model returns 0x0000, 0x1FFF, 0x2000 → fifo_rd_en every 4 clk. dac_data = 0x2000, 0x3FFF, 0x0000, each appearing 2 clk after its rd_en with a dac_valid pulse; dac_clk pattern 1,1,0,0.
- FIFO drains to empty during PLAY → no rd_en on the empty tick, underrun pulse, underrun_cnt = 1, dac_data holds 0x0000. State UNDERRUN until fifo_count = 32, then resumes.
- Drop enable in the cycle after fifo_rd_en → the pending sample is still written to dac_data with dac_valid. State goes to IDLE; dac_clk = 0; no further rd_en.
- Preload underrun_cnt near 0xFFFF via repeated forced underruns → count stops at 0xFFFF while the underrun pulse still fires.
- Assert rst_n low mid-PLAY → all outputs return to reset values asynchronously, with dac_data = 0x2000.

Source files
------------

// File: rtl/adda_pkg.sv
// Shared types and helpers for the DAC playout path: FSM state encoding,
// default sample width and the FIFO-to-DAC code conversion.
package adda_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  // Two's complement to offset binary is an MSB inversion; twos = 0 passes through.
  function automatic logic [DEF_DATA_WIDTH-1:0] conv(
    input logic [DEF_DATA_WIDTH-1:0] x,
    input logic                      twos
  );
    conv = {x[DEF_DATA_WIDTH-1] ^ twos, x[DEF_DATA_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Sample-rate divider: div_cnt, sample tick qualifier and registered DAC clock.
// Counts only while run is high; clr restarts the sample period at zero.
module dac_tick_gen #(
  parameter int unsigned SAMPLE_RATE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic div_zero,
  output logic dac_clk
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_RATE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_RATE - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SAMPLE_RATE / 2);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dac_clk <= 1'b0;
    end else begin
      if (!run || clr || div_cnt == DIV_LAST) div_cnt <= '0;
      else                                    div_cnt <= div_cnt + 1'b1;
      dac_clk <= run && (div_cnt < DIV_HALF);
    end
  end

  assign div_zero = (div_cnt == '0);

endmodule

// File: rtl/dac_playout.sv
// FIFO-to-DAC playout: primes the FIFO, reads one sample per DAC period,
// converts and presents it to the DAC, and counts underrun events.
module dac_playout
  import adda_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH      = 6,
  parameter int unsigned SAMPLE_RATE    = 4,
  parameter int unsigned PRIME_LEVEL    = 32,
  parameter int unsigned TWOS_TO_OFFSET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [CNT_WIDTH-1:0]  fifo_count,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_clk,
  output logic                  dac_valid,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt,
  output logic [1:0]            state
);

  localparam logic TWOS = (TWOS_TO_OFFSET != 0);

  state_t cur_st, nxt_st;
  logic   run, clr, div_zero, tick, prime_ok, cap_pend;

  assign prime_ok = (fifo_count >= CNT_WIDTH'(PRIME_LEVEL));
  assign run      = (cur_st == ST_PLAY) || (cur_st == ST_UNDERRUN);
  assign clr      = (nxt_st == ST_PLAY) && (cur_st != ST_PLAY);
  assign tick     = (cur_st == ST_PLAY) && div_zero;
  assign state    = cur_st;

  dac_tick_gen #(
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .div_zero (div_zero),
    .dac_clk  (dac_clk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_st <= ST_IDLE;
    else        cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    unique case (cur_st)
      ST_IDLE:     nxt_st = ST_PRIME;
      ST_PRIME:    if (prime_ok) nxt_st = ST_PLAY;
      ST_PLAY:     if (tick && fifo_empty) nxt_st = ST_UNDERRUN;
      ST_UNDERRUN: if (prime_ok) nxt_st = ST_PLAY;
      default:     nxt_st = ST_IDLE;
    endcase
    if (!enable) nxt_st = ST_IDLE;
  end

  // The read strobe is registered, so it is gated with enable here: a tick
  // seen while enable drops must not issue a read in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en   <= 1'b0;
      cap_pend     <= 1'b0;
      dac_valid    <= 1'b0;
      dac_data     <= conv(DATA_WIDTH'(0), TWOS);
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      fifo_rd_en <= tick && !fifo_empty && enable;
      cap_pend   <= fifo_rd_en;
      dac_valid  <= cap_pend;
      if (cap_pend) dac_data <= conv(fifo_rd_data, TWOS);
      underrun <= tick && fifo_empty;
      if (tick && fifo_empty && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_playout.sv
// Directed bench for dac_playout: priming, steady playout, underrun and
// recovery, enable drop with a capture in flight, counter saturation, reset.
module tb_dac_playout;

  logic        clk, rst_n, enable;
  logic        fifo_rd_en, fifo_empty;
  logic [13:0] fifo_rd_data, dac_data;
  logic [5:0]  fifo_count;
  logic        dac_clk, dac_valid, underrun;
  logic [15:0] underrun_cnt;
  logic [1:0]  state;

  logic [13:0] mem [64];
  int          rd_ptr;
  int          n_cmp, n_err;

  dac_playout #(
    .DATA_WIDTH     (14),
    .CNT_WIDTH      (6),
    .SAMPLE_RATE    (4),
    .PRIME_LEVEL    (32),
    .TWOS_TO_OFFSET (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .dac_data     (dac_data),
    .dac_clk      (dac_clk),
    .dac_valid    (dac_valid),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a read strobe seen this cycle returns FIFO data the next.
  task automatic step();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) begin
      fifo_rd_data = mem[rd_ptr];
      rd_ptr++;
      if (fifo_count != 0) fifo_count = fifo_count - 6'd1;
      fifo_empty = (fifo_count == 0);
    end
  endtask

  task automatic set_count(input int n);
    fifo_count = 6'(n);
    fifo_empty = (n == 0);
  endtask

  initial begin
    logic [31:0] exp_dac [3];
    logic [31:0] exp_sat [4];
    int cyc, viol, rd_seen;

    n_cmp = 0; n_err = 0; rd_ptr = 0;
    for (int i = 0; i < 64; i++) mem[i] = 14'(i * 37 + 5);
    mem[0] = 14'h0000; mem[1] = 14'h1FFF; mem[2] = 14'h2000;
    mem[31] = 14'h2000; mem[32] = 14'h0123;
    exp_dac[0] = 'h2000; exp_dac[1] = 'h3FFF; exp_dac[2] = 'h0000;
    exp_sat[0] = 'hFFFE; exp_sat[1] = 'hFFFF; exp_sat[2] = 'hFFFF; exp_sat[3] = 'hFFFF;

    enable = 1'b0; fifo_rd_data = '0; set_count(0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_dac_clk", 32'(dac_clk), 0);
    chk("rst_valid", 32'(dac_valid), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ucnt", 32'(underrun_cnt), 0);
    chk("rst_dac_data", 32'(dac_data), 'h2000);

    step(); step();
    rst_n = 1'b1;

    // Priming below threshold
    enable = 1'b1; set_count(10);
    step();
    chk("prime_state", 32'(state), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("prime_hold", 32'(state), 1);
      chk("prime_no_rd", 32'(fifo_rd_en), 0);
    end

    // Threshold reached: PLAY next cycle, first read the cycle after
    set_count(32);
    step();
    chk("play_entry", 32'(state), 2);
    chk("play_entry_rd", 32'(fifo_rd_en), 0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rd_en_tick", 32'(fifo_rd_en), 1);
      chk("dclk_ph0", 32'(dac_clk), 1);
      step();
      chk("rd_en_off", 32'(fifo_rd_en), 0);
      chk("dclk_ph1", 32'(dac_clk), 1);
      step();
      chk("dac_data", 32'(dac_data), exp_dac[k]);
      chk("dac_valid", 32'(dac_valid), 1);
      chk("dclk_ph2", 32'(dac_clk), 0);
      step();
      chk("valid_off", 32'(dac_valid), 0);
      chk("dclk_ph3", 32'(dac_clk), 0);
      step();
    end

    // Drain to empty
    cyc = 0; viol = 0;
    while (cyc < 200 && underrun !== 1'b1) begin
      step();
      cyc++;
      if (fifo_rd_en && fifo_empty) viol++;
    end
    chk("drain_cycles", 32'(cyc), 116);
    chk("rd_while_empty", 32'(viol), 0);
    chk("reads_total", 32'(rd_ptr), 32);
    chk("ur_state", 32'(state), 3);
    chk("ur_cnt1", 32'(underrun_cnt), 1);
    chk("ur_hold_data", 32'(dac_data), 'h0000);
    chk("ur_no_rd", 32'(fifo_rd_en), 0);
    step();
    chk("ur_pulse_end", 32'(underrun), 0);
    rd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (fifo_rd_en) rd_seen++;
    end
    chk("ur_stay", 32'(state), 3);
    chk("ur_no_reads", 32'(rd_seen), 0);

    // Recovery, then enable drops with a capture pending
    set_count(32);
    step();
    chk("resume_state", 32'(state), 2);
    step();
    chk("resume_rd", 32'(fifo_rd_en), 1);
    step();
    enable = 1'b0;
    step();
    chk("drop_state", 32'(state), 0);
    chk("drop_data", 32'(dac_data), 'h2123);
    chk("drop_valid", 32'(dac_valid), 1);
    step();
    chk("drop_valid_end", 32'(dac_valid), 0);
    chk("drop_dclk", 32'(dac_clk), 0);
    rd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fifo_rd_en) rd_seen++;
    end
    chk("idle_no_reads", 32'(rd_seen), 0);
    chk("idle_dclk", 32'(dac_clk), 0);

    // Saturation of the underrun counter
    force dut.underrun_cnt = 16'hFFFD;
    #1 release dut.underrun_cnt;
    fifo_count = 6'd32; fifo_empty = 1'b1; enable = 1'b1;
    step();
    chk("sat_prime", 32'(state), 1);
    step();
    chk("sat_play", 32'(state), 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sat_pulse", 32'(underrun), 1);
      chk("sat_cnt", 32'(underrun_cnt), exp_sat[k]);
      chk("sat_ur_state", 32'(state), 3);
      step();
      chk("sat_pulse_end", 32'(underrun), 0);
      chk("sat_no_rd", 32'(fifo_rd_en), 0);
    end

    // Asynchronous reset in PLAY with a read in flight
    set_count(40);
    step();
    chk("pre_rst_rd", 32'(fifo_rd_en), 1);
    chk("pre_rst_dclk", 32'(dac_clk), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_rd_en", 32'(fifo_rd_en), 0);
    chk("arst_dclk", 32'(dac_clk), 0);
    chk("arst_underrun", 32'(underrun), 0);
    chk("arst_ucnt", 32'(underrun_cnt), 0);
    chk("arst_dac_data", 32'(dac_data), 'h2000);
    enable = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(dac_valid), 0);
    chk("post_rst_data", 32'(dac_data), 'h2000);
    step();
    chk("post_rst_valid2", 32'(dac_valid), 0);
    chk("post_rst_state", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
